mem_responder: RTL

Memory-side responder for the CPU's `mem_cmd`/`mem_addr` bus. It serves MREAD and MWRITE commands from a single-port synchronous word RAM with one-cycle read latency, and decodes memory-mapped switch and LED registers. A boot loader fills RAM from a streaming load port after reset. `busy` holds the CPU in reset until boot completes.

---
 rtl/mem_responder_if.sv | 25 ++
 rtl/mem_responder.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mem_responder_if.sv
// Bus bundle between the CPU-side memory port and mem_responder:
// command/address/data, MMIO switch and LED lines, boot load stream and status.
interface mem_responder_if;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic [7:0]  sw;
    logic [7:0]  led;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_last;
    logic        busy;
    logic        err;

    modport master (
        output mem_cmd, mem_addr, write_data, sw, load_valid, load_data, load_last,
        input  read_data, led, busy, err
    );

    modport slave (
        input  mem_cmd, mem_addr, write_data, sw, load_valid, load_data, load_last,
        output read_data, led, busy, err
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: single-port 16-bit word RAM with one-cycle read latency,
// boot loader filling RAM from a streaming load port, sticky access-error flag.
// Optional MMIO switch/LED registers are enabled by defining MEM_RESPONDER_MMIO_EN;
// without it every address >= DEPTH is an error and led is tied low.
module mem_responder #(
    parameter int         DEPTH    = 256,
    parameter logic [8:0] SW_ADDR  = 9'h140,
    parameter logic [8:0] LED_ADDR = 9'h100
) (
    input logic            clk,
    input logic            rst,
    mem_responder_if.slave bus
);

    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] PTR_LAST = 8'(DEPTH - 1);

    typedef enum logic {
        S_BOOT,
        S_RUN
    } state_t;

    typedef enum logic [1:0] {
        MNONE    = 2'b00,
        MREAD    = 2'b01,
        MWRITE   = 2'b10,
        MILLEGAL = 2'b11
    } cmd_t;

    state_t      state;
    logic [7:0]  ptr;
    logic [15:0] read_q;
    logic [7:0]  led_q;
    logic        err_q;
    logic        busy_q;

    logic [15:0] ram [DEPTH];

    logic          in_ram;
    logic          is_sw;
    logic          is_led;
    logic          cmd_err;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [15:0]   ram_wdata;

    // Address decode and error classification of the current command
    always_comb begin
        in_ram = (10'(bus.mem_addr) < 10'(DEPTH));
        is_sw  = 1'b0;
        is_led = 1'b0;
`ifdef MEM_RESPONDER_MMIO_EN
        is_sw  = (bus.mem_addr == SW_ADDR);
        is_led = (bus.mem_addr == LED_ADDR);
`endif
        cmd_err = (bus.mem_cmd == MILLEGAL)
               || ((bus.mem_cmd == MREAD)  && !in_ram && !is_sw)
               || ((bus.mem_cmd == MWRITE) && !in_ram && !is_led);
    end

    // Single RAM write port shared by the boot loader and CPU writes
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        if (!rst) begin
            if (state == S_BOOT) begin
                ram_we    = bus.load_valid;
                ram_waddr = ptr[AW-1:0];
                ram_wdata = bus.load_data;
            end else begin
                ram_we    = (bus.mem_cmd == MWRITE) && in_ram;
                ram_waddr = bus.mem_addr[AW-1:0];
                ram_wdata = bus.write_data;
            end
        end
    end

    // RAM array has no reset so contents survive a mid-run reset
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_waddr] <= ram_wdata;
        end
    end

    // Boot/run FSM with registered read data, LED, error and busy outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_BOOT;
            ptr    <= '0;
            read_q <= '0;
            led_q  <= '0;
            err_q  <= 1'b0;
            busy_q <= 1'b1;
        end else begin
            case (state)
                S_BOOT: begin
                    if (bus.load_valid) begin
                        // Pointer holds at the top word instead of wrapping
                        if (bus.load_last || (ptr == PTR_LAST)) begin
                            state  <= S_RUN;
                            busy_q <= 1'b0;
                        end else begin
                            ptr <= ptr + 8'd1;
                        end
                    end
                end
                S_RUN: begin
                    if (cmd_err) begin
                        err_q <= 1'b1;
                    end else if (bus.mem_cmd == MREAD) begin
                        if (in_ram) begin
                            read_q <= ram[bus.mem_addr[AW-1:0]];
                        end else if (is_sw) begin
                            read_q <= {8'h00, bus.sw};
                        end
                    end else if ((bus.mem_cmd == MWRITE) && is_led) begin
                        led_q <= bus.write_data[7:0];
                    end
                end
                default: state <= S_BOOT;
            endcase
        end
    end

`ifdef MEM_RESPONDER_MMIO_EN
    assign bus.led = led_q;
`else
    logic unused_mmio;
    assign unused_mmio = ^{bus.sw, SW_ADDR, LED_ADDR, led_q};
    assign bus.led     = 8'h00;
`endif

    assign bus.read_data = read_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;

endmodule
